// File: rtl/conv_sequencer.sv
// Convolution sequencer: loads the kernel once, then streams every valid
// K x K image window through the MAC engine and writes each result out.
module conv_sequencer #(
  parameter int unsigned KERNEL_SIZE     = 3,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SRAM_ADDR_WIDTH = 8,
  parameter int unsigned IMG_W           = 8,
  parameter int unsigned IMG_H           = 8,
  parameter int unsigned OUT_ADDR_WIDTH  = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_img_base,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_kern_base,
  output logic                       o_sram_rd,
  output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
  output logic                       o_eng_valid,
  output logic                       o_eng_sel,
  output logic                       o_eng_first,
  output logic                       o_eng_last,
  input  logic                       i_eng_done,
  input  logic [DATA_WIDTH-1:0]      i_eng_result,
  output logic                       o_wr_en,
  output logic [OUT_ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [DATA_WIDTH-1:0]      o_wr_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned K     = KERNEL_SIZE;
  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;
  localparam int unsigned KW    = $clog2(K + 1);
  localparam int unsigned CW    = $clog2(OUT_W + 1);
  localparam int unsigned RW    = $clog2(OUT_H + 1);
  localparam int unsigned AW    = SRAM_ADDR_WIDTH;
  localparam int unsigned OW    = OUT_ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KERNEL,
    S_LOAD_WINDOW,
    S_WAIT_RESULT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] img_base_q, img_base_d, kern_base_q, kern_base_d;
  logic [DW-1:0] res_q, res_d;

  logic          sram_rd_q, sram_rd_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic          sel_q, sel_d, first_q, first_d, last_q, last_d;
  logic          eng_valid_q, eng_valid_d, eng_sel_q, eng_sel_d;
  logic          eng_first_q, eng_first_d, eng_last_q, eng_last_d;
  logic          wr_en_q, wr_en_d;
  logic [OW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          elem_end;
  logic          pix_end;

  assign elem_end = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1));
  assign pix_end  = (col_q == CW'(OUT_W - 1)) && (row_q == RW'(OUT_H - 1));

  // Next state and traversal counters; abort overrides everything outside IDLE.
  always_comb begin
    state_d     = state_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    col_d       = col_q;
    row_d       = row_q;
    img_base_d  = img_base_q;
    kern_base_d = kern_base_q;
    res_d       = res_q;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          img_base_d  = i_img_base;
          kern_base_d = i_kern_base;
          kx_d        = '0;
          ky_d        = '0;
          col_d       = '0;
          row_d       = '0;
          state_d     = S_LOAD_KERNEL;
        end
      end
      S_LOAD_KERNEL, S_LOAD_WINDOW: begin
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          ky_d = ky_q + KW'(1);
        end else begin
          kx_d = kx_q + KW'(1);
        end
        if (elem_end) begin
          ky_d    = '0;
          state_d = (state_q == S_LOAD_KERNEL) ? S_LOAD_WINDOW : S_WAIT_RESULT;
        end
      end
      S_WAIT_RESULT: begin
        if (i_eng_done) begin
          res_d   = i_eng_result;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (pix_end) begin
          state_d = S_DONE;
        end else begin
          if (col_q == CW'(OUT_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          state_d = S_LOAD_WINDOW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Registered outputs are decoded from the upcoming state so they line up with it.
  always_comb begin
    sram_rd_d   = 1'b0;
    sram_addr_d = '0;
    sel_d       = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    eng_valid_d = sram_rd_q;
    eng_sel_d   = sel_q;
    eng_first_d = first_q;
    eng_last_d  = last_q;

    if ((state_d == S_LOAD_KERNEL) || (state_d == S_LOAD_WINDOW)) begin
      sram_rd_d = 1'b1;
      sel_d     = (state_d == S_LOAD_WINDOW);
      first_d   = (kx_d == '0) && (ky_d == '0);
      last_d    = (kx_d == KW'(K - 1)) && (ky_d == KW'(K - 1));
      if (sel_d) begin
        sram_addr_d = img_base_d + (AW'(row_d) + AW'(ky_d)) * AW'(IMG_W)
                    + AW'(col_d) + AW'(kx_d);
      end else begin
        sram_addr_d = kern_base_d + AW'(ky_d) * AW'(K) + AW'(kx_d);
      end
    end

    if (state_d == S_WRITE) begin
      wr_en_d   = 1'b1;
      wr_addr_d = OW'(row_d) * OW'(OUT_W) + OW'(col_d);
      wr_data_d = res_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      kx_q        <= '0;
      ky_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      img_base_q  <= '0;
      kern_base_q <= '0;
      res_q       <= '0;
      sram_rd_q   <= 1'b0;
      sram_addr_q <= '0;
      sel_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      eng_valid_q <= 1'b0;
      eng_sel_q   <= 1'b0;
      eng_first_q <= 1'b0;
      eng_last_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      col_q       <= col_d;
      row_q       <= row_d;
      img_base_q  <= img_base_d;
      kern_base_q <= kern_base_d;
      res_q       <= res_d;
      sram_rd_q   <= sram_rd_d;
      sram_addr_q <= sram_addr_d;
      sel_q       <= sel_d;
      first_q     <= first_d;
      last_q      <= last_d;
      eng_valid_q <= eng_valid_d;
      eng_sel_q   <= eng_sel_d;
      eng_first_q <= eng_first_d;
      eng_last_q  <= eng_last_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_sram_rd   = sram_rd_q;
  assign o_sram_addr = sram_addr_q;
  assign o_eng_valid = eng_valid_q;
  assign o_eng_sel   = eng_sel_q;
  assign o_eng_first = eng_first_q;
  assign o_eng_last  = eng_last_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer on a 4x4 image with a 3x3 kernel,
// using a frame-level read/write model and a small engine responder.
module tb_conv_sequencer;

  localparam int K  = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int OW = IW - K + 1;
  localparam int OH = IH - K + 1;
  localparam int KK = K * K;

  typedef struct packed {
    logic [7:0] addr;
    logic       sel;
    logic       first;
    logic       last;
  } rd_t;

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] data;
  } wr_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [7:0] i_img_base = '0;
  logic [7:0] i_kern_base = '0;
  logic       o_sram_rd;
  logic [7:0] o_sram_addr;
  logic       o_eng_valid, o_eng_sel, o_eng_first, o_eng_last;
  logic       i_eng_done = 1'b0;
  logic [7:0] i_eng_result = '0;
  logic       o_wr_en;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy, o_done;

  conv_sequencer #(
    .KERNEL_SIZE(3), .DATA_WIDTH(8), .SRAM_ADDR_WIDTH(8),
    .IMG_W(IW), .IMG_H(IH), .OUT_ADDR_WIDTH(6)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_img_base(i_img_base), .i_kern_base(i_kern_base),
    .o_sram_rd(o_sram_rd), .o_sram_addr(o_sram_addr),
    .o_eng_valid(o_eng_valid), .o_eng_sel(o_eng_sel),
    .o_eng_first(o_eng_first), .o_eng_last(o_eng_last),
    .i_eng_done(i_eng_done), .i_eng_result(i_eng_result),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  rd_t exp_rd[$];
  wr_t exp_wr[$];
  rd_t prev_e;
  bit  prev_v = 1'b0;
  int  eng_cnt = 0;
  int  eng_delay = 2;
  int  win_idx = 0;
  int  abort_at = -1;
  bit  aborted = 1'b0;
  bit  abort_now = 1'b0;
  int  spur_left = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // Whole-frame expectation: kernel load, then every window row-major.
  task automatic model_frame(input int ib, input int kb);
    rd_t e;
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < KK; i++) begin
      e.addr = 8'(kb + i); e.sel = 1'b0;
      e.first = (i == 0); e.last = (i == KK - 1);
      exp_rd.push_back(e);
    end
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            e.addr  = 8'(ib + (r + ky) * IW + c + kx);
            e.sel   = 1'b1;
            e.first = (ky == 0) && (kx == 0);
            e.last  = (ky == K - 1) && (kx == K - 1);
            exp_rd.push_back(e);
          end
  endtask

  // Negedge observer and engine responder.
  task automatic mon();
    rd_t e;
    wr_t w;
    int  d;
    i_eng_done = 1'b0;
    i_abort    = 1'b0;
    if (i_rst) begin
      prev_v  = 1'b0;
      eng_cnt = 0;
      return;
    end
    if (abort_now) begin
      i_abort   = 1'b1;
      abort_now = 1'b0;
    end
    check("eng_valid", 32'(o_eng_valid), 32'(prev_v));
    if (prev_v) begin
      check("eng_sel", 32'(o_eng_sel), 32'(prev_e.sel));
      check("eng_first", 32'(o_eng_first), 32'(prev_e.first));
      check("eng_last", 32'(o_eng_last), 32'(prev_e.last));
    end
    prev_v = 1'b0;
    if (o_sram_rd) begin
      if (exp_rd.size() == 0) begin
        check("rd_extra", 32'(o_sram_rd), 32'd0);
      end else begin
        e = exp_rd.pop_front();
        check("rd_addr", 32'(o_sram_addr), 32'(e.addr));
        prev_e = e;
        prev_v = 1'b1;
        if (spur_left > 0 && e.sel && !e.first && !e.last) begin
          i_eng_done   = 1'b1;
          i_eng_result = 8'hEE;
          spur_left--;
        end
      end
    end
    if (o_wr_en) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        check("wr_extra", 32'(o_wr_en), 32'd0);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(o_wr_addr), 32'(w.idx));
        check("wr_data", 32'(o_wr_data), 32'(w.data));
      end
    end
    if (o_done) begin
      done_cnt++;
      check("done_wr_left", 32'(exp_wr.size()), 32'd0);
      check("done_rd_left", 32'(exp_rd.size()), 32'd0);
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        d            = int'($urandom_range(0, 255));
        i_eng_done   = 1'b1;
        i_eng_result = 8'(d);
        if (win_idx == abort_at) begin
          i_abort  = 1'b1;
          aborted  = 1'b1;
          abort_at = -1;
          exp_rd.delete();
        end else begin
          w.idx  = 6'(win_idx);
          w.data = 8'(d);
          exp_wr.push_back(w);
        end
        win_idx++;
      end
    end
    if (o_eng_valid && o_eng_sel && o_eng_last) eng_cnt = eng_delay;
  endtask

  task automatic cyc();
    @(negedge i_clk);
    mon();
    @(posedge i_clk);
    #2;
  endtask

  task automatic run_frame(input int ib, input int kb, input int dly, input bit noise,
                           input int spur, input int abort_pix);
    int  d0, w0;
    bit  stop;
    model_frame(ib, kb);
    win_idx = 0; eng_delay = dly; spur_left = spur;
    abort_at = abort_pix; aborted = 1'b0;
    d0 = done_cnt; w0 = wr_cnt; stop = 1'b0;
    i_img_base = 8'(ib); i_kern_base = 8'(kb); i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    i_img_base = 8'($urandom); i_kern_base = 8'($urandom);
    for (int n = 0; n < 4000 && !stop; n++) begin
      i_start = noise && o_busy && ($urandom_range(0, 2) == 0);
      cyc();
      stop = (done_cnt != d0) || aborted;
    end
    i_start = 1'b0;
    check("frame_finished", 32'(stop), 32'd1);
    check("busy_after", 32'(o_busy), 32'd0);
    check("wr_en_after", 32'(o_wr_en), 32'd0);
    if (abort_pix < 0) begin
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("write_count", 32'(wr_cnt - w0), 32'(OW * OH));
      check("done_pulse_len", 32'(o_done), 32'd0);
    end else begin
      for (int n = 0; n < 6; n++) cyc();
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_writes", 32'(wr_cnt - w0), 32'(abort_pix));
      check("abort_idle", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    cyc();
    cyc();
    check("rst_rd", 32'(o_sram_rd), 32'd0);
    check("rst_addr", 32'(o_sram_addr), 32'd0);
    check("rst_valid", 32'(o_eng_valid), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_rst = 1'b0;
    cyc();

    run_frame(0, 100, 2, 1'b0, 0, -1);
    run_frame(0, 100, 20, 1'b1, 1, -1);
    run_frame(10, 200, 3, 1'b0, 0, 1);
    run_frame(10, 200, 1, 1'b0, 0, -1);

    // Abort together with start in IDLE keeps the block idle.
    exp_rd.delete();
    abort_now = 1'b1;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    check("idle_abort_start", 32'(o_busy), 32'd0);

    // Asynchronous reset in the middle of the kernel load.
    model_frame(7, 30);
    win_idx = 0; eng_delay = 2; abort_at = -1;
    i_img_base = 8'd7; i_kern_base = 8'd30; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int n = 0; n < 3; n++) cyc();
    check("pre_rst_rd", 32'(o_sram_rd), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_rd", 32'(o_sram_rd), 32'd0);
    check("mid_rst_addr", 32'(o_sram_addr), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_wr", 32'(o_wr_en), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    cyc();
    i_rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      check("post_rst_idle", 32'(o_busy), 32'd0);
    end

    for (int t = 0; t < 4; t++)
      run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, 5)), 1'b1, int'($urandom_range(0, 1)), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
